// File: rtl/forward_select_unit.sv
// EX-stage operand forwarding selectors and load-use stall generation, driven
// from a private shadow of the destination-register info for EX, MEM and WB.
module forward_select_unit #(
    parameter int RegAddrBits = 5,
    parameter int CntBits     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_Valid,
    input  logic [RegAddrBits-1:0] ID_Rs,
    input  logic [RegAddrBits-1:0] ID_Rt,
    input  logic [RegAddrBits-1:0] ID_WriteReg,
    input  logic                   ID_RegWrite,
    input  logic                   ID_MemRead,
    input  logic                   Flush,
    output logic [1:0]             ForwardA,
    output logic [1:0]             ForwardB,
    output logic                   Stall,
    output logic [CntBits-1:0]     StallCount
);

    localparam logic [1:0] SelRegFile = 2'b00;
    localparam logic [1:0] SelMemWb   = 2'b01;
    localparam logic [1:0] SelExMem   = 2'b10;

    logic                   ex_valid, ex_rw, ex_mr;
    logic [RegAddrBits-1:0] ex_wr;
    logic                   mem_valid, mem_rw;
    logic [RegAddrBits-1:0] mem_wr;
    logic                   wb_valid, wb_rw;
    logic [RegAddrBits-1:0] wb_wr;

    logic hazard;
    logic bubble;

    // The register file writes before it reads, so WB is tracked but never forwarded from.
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rw, wb_wr};

    function automatic logic [1:0] fwd_sel(input logic [RegAddrBits-1:0] src);
        logic [1:0] sel;
        sel = SelRegFile;
        if (src == '0)
            sel = SelRegFile;
        else if (ex_valid && ex_rw && (ex_wr == src))
            sel = SelExMem;
        else if (mem_valid && mem_rw && (mem_wr == src))
            sel = SelMemWb;
        return sel;
    endfunction

    assign hazard = ID_Valid && ex_valid && ex_mr && ex_rw && (ex_wr != '0) &&
                    ((ex_wr == ID_Rs) || (ex_wr == ID_Rt));
    assign Stall  = hazard && !Flush;
    assign bubble = Flush || Stall || !ID_Valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_rw      <= 1'b0;
            ex_mr      <= 1'b0;
            ex_wr      <= '0;
            mem_valid  <= 1'b0;
            mem_rw     <= 1'b0;
            mem_wr     <= '0;
            wb_valid   <= 1'b0;
            wb_rw      <= 1'b0;
            wb_wr      <= '0;
            ForwardA   <= SelRegFile;
            ForwardB   <= SelRegFile;
            StallCount <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_rw    <= ex_rw;
            mem_wr    <= ex_wr;
            wb_valid  <= mem_valid;
            wb_rw     <= mem_rw;
            wb_wr     <= mem_wr;
            if (bubble) begin
                ex_valid <= 1'b0;
                ex_rw    <= 1'b0;
                ex_mr    <= 1'b0;
                ex_wr    <= '0;
                ForwardA <= SelRegFile;
                ForwardB <= SelRegFile;
            end else begin
                ex_valid <= 1'b1;
                ex_rw    <= ID_RegWrite;
                ex_mr    <= ID_MemRead;
                ex_wr    <= ID_WriteReg;
                ForwardA <= fwd_sel(ID_Rs);
                ForwardB <= fwd_sel(ID_Rt);
            end
            // Saturate rather than wrap so a long stall storm stays visible.
            if (Stall && (StallCount != '1))
                StallCount <= StallCount + 1'b1;
        end
    end

endmodule
